// File: rtl/pn_spread_ctrl.sv
// Direct-sequence spreading controller: spreads each accepted data bit over one
// full 31-chip period of a 5-stage m-sequence (1+x^2+x^5), chips paced by CHIP_DIV.
module pn_spread_ctrl #(
   parameter int unsigned CHIP_DIV = 1,
   parameter logic [4:0]  SEED     = 5'h1F
) (
   input  logic       clk_1m,
   input  logic       rst,
   input  logic       en,
   input  logic       bit_data,
   input  logic       bit_valid,
   output logic       bit_ready,
   output logic       chip_out,
   output logic       pn_chip,
   output logic       chip_stb,
   output logic       bit_start,
   output logic       active,
   output logic [7:0] underrun_cnt
);

   localparam int unsigned DIV_W = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CHIP_DIV - 1);
   localparam logic [4:0] SEED_EFF  = (SEED == 5'h00) ? 5'h1F : SEED;
   localparam logic [4:0] CHIP_LAST = 5'd30;
   localparam logic [7:0] UND_MAX   = 8'hFF;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [4:0]       lfsr_q, lfsr_d;
   logic [4:0]       chip_idx_q, chip_idx_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             bit_q, bit_d;
   logic             chip_out_q, chip_out_d;
   logic             pn_q, pn_d;
   logic             stb_q, stb_d;
   logic             bstart_q, bstart_d;
   logic             active_q, active_d;
   logic [7:0]       und_q, und_d;
   logic             ready_c;
   logic [4:0]       lfsr_step_c;

   assign lfsr_step_c = {lfsr_q[3:0], lfsr_q[1] ^ lfsr_q[4]};

   // Output regs hold the values for the cycle that follows the edge
   always_ff @(posedge clk_1m) begin
      if (rst) begin
         state_q    <= S_IDLE;
         lfsr_q     <= SEED_EFF;
         chip_idx_q <= 5'd0;
         div_q      <= '0;
         bit_q      <= 1'b0;
         chip_out_q <= 1'b0;
         pn_q       <= 1'b0;
         stb_q      <= 1'b0;
         bstart_q   <= 1'b0;
         active_q   <= 1'b0;
         und_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         chip_idx_q <= chip_idx_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         chip_out_q <= chip_out_d;
         pn_q       <= pn_d;
         stb_q      <= stb_d;
         bstart_q   <= bstart_d;
         active_q   <= active_d;
         und_q      <= und_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      chip_idx_d = chip_idx_q;
      div_d      = div_q;
      bit_d      = bit_q;
      chip_out_d = chip_out_q;
      pn_d       = pn_q;
      stb_d      = 1'b0;
      bstart_d   = 1'b0;
      und_d      = und_q;
      ready_c    = 1'b0;

      case (state_q)
         S_IDLE: begin
            ready_c    = en;
            pn_d       = 1'b0;
            chip_out_d = 1'b0;
            if (en && bit_valid) begin
               state_d    = S_RUN;
               lfsr_d     = SEED_EFF;
               bit_d      = bit_data;
               chip_idx_d = 5'd0;
               div_d      = '0;
               stb_d      = 1'b1;
               bstart_d   = 1'b1;
               pn_d       = SEED_EFF[4];
               chip_out_d = bit_data ^ SEED_EFF[4];
            end
         end
         S_RUN: begin
            if (div_q == DIV_LAST) begin
               lfsr_d = lfsr_step_c;
               div_d  = '0;
               if (chip_idx_q == CHIP_LAST) begin
                  // Bit boundary: the stepped LFSR is back at SEED, so no reload
                  ready_c    = en;
                  chip_idx_d = 5'd0;
                  if (en && bit_valid) begin
                     bit_d      = bit_data;
                     stb_d      = 1'b1;
                     bstart_d   = 1'b1;
                     pn_d       = lfsr_step_c[4];
                     chip_out_d = bit_data ^ lfsr_step_c[4];
                  end else begin
                     state_d    = S_IDLE;
                     pn_d       = 1'b0;
                     chip_out_d = 1'b0;
                     if (en && (und_q != UND_MAX)) begin
                        und_d = und_q + 8'd1;
                     end
                  end
               end else begin
                  chip_idx_d = chip_idx_q + 5'd1;
                  stb_d      = 1'b1;
                  pn_d       = lfsr_step_c[4];
                  chip_out_d = bit_q ^ lfsr_step_c[4];
               end
            end else begin
               div_d = DIV_W'(div_q + 1'b1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      active_d = (state_d == S_RUN);
   end

   assign bit_ready    = ready_c & ~rst;
   assign chip_out     = chip_out_q;
   assign pn_chip      = pn_q;
   assign chip_stb     = stb_q;
   assign bit_start    = bstart_q;
   assign active       = active_q;
   assign underrun_cnt = und_q;

endmodule

// File: tb/tb_pn_spread_ctrl.sv
// Bench for pn_spread_ctrl: two instances (CHIP_DIV=1 and CHIP_DIV=4) checked against
// the reference m-sequence and a per-bit chip/underrun model.
module tb_pn_spread_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, en_a, data_a, valid_a, ready_a, cout_a, pn_a, stb_a, bs_a, act_a;
   logic [7:0] und_a;
   logic       rst_b, en_b, data_b, valid_b, ready_b, cout_b, pn_b, stb_b, bs_b, act_b;
   logic [7:0] und_b;

   int total = 0;
   int bad   = 0;
   int exp_und_a = 0;
   int exp_und_b = 0;

   // Expected PN chip sequence from SEED=1F, chip 0 first
   logic [0:30] pn_seq = 31'b1111100110100100001010111011000;

   pn_spread_ctrl #(.CHIP_DIV(1), .SEED(5'h1F)) dut_a (
      .clk_1m(clk), .rst(rst_a), .en(en_a), .bit_data(data_a), .bit_valid(valid_a),
      .bit_ready(ready_a), .chip_out(cout_a), .pn_chip(pn_a), .chip_stb(stb_a),
      .bit_start(bs_a), .active(act_a), .underrun_cnt(und_a)
   );

   pn_spread_ctrl #(.CHIP_DIV(4), .SEED(5'h1F)) dut_b (
      .clk_1m(clk), .rst(rst_b), .en(en_b), .bit_data(data_b), .bit_valid(valid_b),
      .bit_ready(ready_b), .chip_out(cout_b), .pn_chip(pn_b), .chip_stb(stb_b),
      .bit_start(bs_b), .active(act_b), .underrun_cnt(und_b)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Sends n bits on instance A back-to-back; end_en is en at the final boundary
   task automatic send_a(input int n, input logic [15:0] bits, input logic end_en);
      logic [5:0] exp_v;
      logic [5:0] act_v;
      logic       b;
      en_a = 1'b1; valid_a = 1'b1; data_a = bits[0];
      #1;
      total++;
      if (ready_a !== 1'b1) begin
         bad++;
         $display("FAIL send_ready_idle got=%b want=1", ready_a);
      end
      cyc();
      for (int i = 0; i < n; i++) begin
         b = bits[i];
         for (int k = 0; k < 31; k++) begin
            if (k == 30) begin
               if (i < n - 1) begin
                  en_a = 1'b1; valid_a = 1'b1; data_a = bits[i+1];
               end else begin
                  en_a = end_en; valid_a = end_en ? 1'b0 : 1'($urandom); data_a = 1'($urandom);
               end
            end else begin
               en_a = 1'($urandom); valid_a = 1'($urandom); data_a = 1'($urandom);
            end
            #1;
            exp_v = {1'b1, (k == 0), pn_seq[k], b ^ pn_seq[k], 1'b1, (k == 30) ? en_a : 1'b0};
            act_v = {stb_a, bs_a, pn_a, cout_a, act_a, ready_a};
            total++;
            if (act_v !== exp_v) begin
               bad++;
               $display("FAIL chip_a bit=%0d chip=%0d {stb,bs,pn,out,act,rdy} got=%b want=%b",
                        i, k, act_v, exp_v);
            end
            cyc();
         end
      end
      if (end_en && exp_und_a < 255) exp_und_a++;
      en_a = 1'b0; valid_a = 1'b0;
      #1;
      total++;
      if ({stb_a, bs_a, pn_a, cout_a, act_a, ready_a} !== 6'b0 || und_a !== 8'(exp_und_a)) begin
         bad++;
         $display("FAIL idle_after_a outs=%b und=%0d want outs=000000 und=%0d",
                  {stb_a, bs_a, pn_a, cout_a, act_a, ready_a}, und_a, exp_und_a);
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1;
      en_a = 1'b0; valid_a = 1'b0; data_a = 1'b0;
      en_b = 1'b0; valid_b = 1'b0; data_b = 1'b0;
      repeat (3) cyc();
      total++;
      if ({ready_a, cout_a, pn_a, stb_a, bs_a, act_a} !== 6'b0 || und_a !== 8'd0) begin
         bad++;
         $display("FAIL reset_a outs=%b und=%0d want 0", {ready_a, cout_a, pn_a, stb_a, bs_a, act_a}, und_a);
      end
      total++;
      if ({ready_b, cout_b, pn_b, stb_b, bs_b, act_b} !== 6'b0 || und_b !== 8'd0) begin
         bad++;
         $display("FAIL reset_b outs=%b und=%0d want 0", {ready_b, cout_b, pn_b, stb_b, bs_b, act_b}, und_b);
      end
      rst_a = 1'b0; rst_b = 1'b0;
      cyc();
      en_a = 1'b1;
      #1;
      total++;
      if (ready_a !== 1'b1 || act_a !== 1'b0 || und_a !== 8'd0) begin
         bad++;
         $display("FAIL idle_en rdy=%b act=%b und=%0d want 1 0 0", ready_a, act_a, und_a);
      end
      en_a = 1'b0;
      cyc();
   endtask

   task automatic test_single();
      send_a(1, 16'h0000, 1'b1);
      send_a(1, 16'h0001, 1'b1);
   endtask

   task automatic test_back_to_back();
      send_a(3, 16'b101, 1'b1);
      send_a(8, 16'($urandom), 1'b0);
   endtask

   task automatic test_starve();
      send_a(1, 16'($urandom), 1'b0);
      for (int r = 0; r < 300; r++) send_a(1, 16'($urandom), 1'b1);
      total++;
      if (und_a !== 8'd255) begin
         bad++;
         $display("FAIL underrun_sat got=%0d want=255", und_a);
      end
      send_a(1, 16'($urandom), 1'b0);
   endtask

   task automatic test_reset_mid();
      logic b;
      b = 1'($urandom);
      en_a = 1'b1; valid_a = 1'b1; data_a = b;
      cyc();
      valid_a = 1'b0;
      for (int k = 0; k <= 12; k++) begin
         #1;
         total++;
         if (pn_a !== pn_seq[k] || cout_a !== (b ^ pn_seq[k])) begin
            bad++;
            $display("FAIL pre_abort chip=%0d pn=%b out=%b want %b %b", k, pn_a, cout_a, pn_seq[k], b ^ pn_seq[k]);
         end
         if (k == 12) rst_a = 1'b1;
         cyc();
      end
      en_a = 1'b0;
      #1;
      total++;
      if ({ready_a, cout_a, pn_a, stb_a, bs_a, act_a} !== 6'b0 || und_a !== 8'd0) begin
         bad++;
         $display("FAIL abort_reset outs=%b und=%0d want 0", {ready_a, cout_a, pn_a, stb_a, bs_a, act_a}, und_a);
      end
      exp_und_a = 0;
      rst_a = 1'b0;
      cyc();
      send_a(1, 16'($urandom), 1'b0);
   endtask

   task automatic test_div4();
      logic       b;
      logic [5:0] exp_v;
      logic [5:0] act_v;
      int         k;
      int         ph;
      for (int rep = 0; rep < 2; rep++) begin
         b = 1'($urandom);
         en_b = 1'b1; valid_b = 1'b1; data_b = b;
         #1;
         total++;
         if (ready_b !== 1'b1) begin
            bad++;
            $display("FAIL div4_ready_idle got=%b want=1", ready_b);
         end
         cyc();
         for (int c = 1; c <= 124; c++) begin
            k  = (c - 1) / 4;
            ph = (c - 1) % 4;
            if (c == 124) begin
               en_b = 1'b1; valid_b = 1'b0;
            end else begin
               en_b = 1'($urandom); valid_b = 1'($urandom);
            end
            data_b = 1'($urandom);
            #1;
            exp_v = {(ph == 0), (c == 1), pn_seq[k], b ^ pn_seq[k], 1'b1, (c == 124)};
            act_v = {stb_b, bs_b, pn_b, cout_b, act_b, ready_b};
            total++;
            if (act_v !== exp_v) begin
               bad++;
               $display("FAIL chip_b cyc=%0d {stb,bs,pn,out,act,rdy} got=%b want=%b", c, act_v, exp_v);
            end
            cyc();
         end
         exp_und_b++;
         en_b = 1'b0; valid_b = 1'b0;
         #1;
         total++;
         if ({stb_b, bs_b, pn_b, cout_b, act_b, ready_b} !== 6'b0 || und_b !== 8'(exp_und_b)) begin
            bad++;
            $display("FAIL idle_after_b outs=%b und=%0d want 000000 und=%0d",
                     {stb_b, bs_b, pn_b, cout_b, act_b, ready_b}, und_b, exp_und_b);
         end
         cyc();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_div4();
      test_starve();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
